instr_encode_loader: RTL and testbench
======================================

// Module: instr_encode_loader
// PURPOSE
// - Inverse of the control unit: turns field-level requests (class, funct3, alt, rd, rs1, rs2, imm) into RV32IM words.
// - Writes the words sequentially into instruction memory through a valid/ready write port.
// - Used as the bench/boot program loader that fills IMEM before the pipeline leaves reset.
// - Flags illegal immediates and IMEM overflow.
// PARAMETERS
// - ADDR_WIDTH  10   IMEM word-address width; capacity is 2**ADDR_WIDTH words.
// - NOP_WORD    32'h00000013   Word written in place of an illegal request (addi x0,x0,0).
// PORTS
// - clk         in   1   Single clock, rising edge.
// - reset_n     in   1   Asynchronous, active-low reset.
// - start       in   1   Pulse in IDLE: loads base_addr and enters LOAD.
// - base_addr   in   AW  First IMEM word address.
// - req_valid   in   1   Request valid.
// - req_ready   out  1   Request accepted when req_valid && req_ready.
// - req_last    in   1   Marks the final request of the program.
// - req_class   in   4   0 R, 1 OPIMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 MEXT; others illegal.
// - req_funct3  in   3   funct3 field.
// - req_alt     in   1   funct7[5] for SUB/SRA/SRAI.
// - req_rd, req_rs1, req_rs2   in  5 each   Register indices.
// - req_imm     in   32  Signed byte-offset or value. U-type takes the full 32-bit value.
// - imem_we     out  1   IMEM write valid.
// - imem_ready  in   1   IMEM accepts the write when imem_we && imem_ready.
// - imem_addr   out  AW  Word address.
// - imem_wdata  out  32  Encoded instruction.
// - busy        out  1   State != IDLE.
// - done        out  1   One-cycle pulse on the DRAIN->IDLE transition.
// - word_count  out  AW+1  Words written since start.
// - err         out  1   Sticky illegal-request flag; cleared by start.
// - err_addr    out  AW  Address of the first illegal word.
// - full        out  1   Sticky capacity flag; cleared by start.
// BEHAVIOUR
// - Reset values: all outputs 0, req_ready 0, state IDLE, internal address = 0.
// - FSM transitions:
//   - IDLE -> LOAD on start.
//   - LOAD -> DRAIN on accepting req_last, or when full sets.
//   - DRAIN -> IDLE once the output register is empty, pulsing done.
// - start is ignored outside IDLE.
// - Handshake: req_ready = (state==LOAD) && !full && (!imem_we || imem_ready).
// - Latency: request accepted at edge N appears on imem_we/addr/wdata from edge N.
//   - The output register holds it stable until imem_ready.
//   - Back-to-back requests give one word per cycle.
// - Address increments by 1 on each IMEM handshake.
//   - The handshake that writes word 2**AW-1 sets full.
//   - Wrap-around never happens; further requests are refused.
// - Encoding opcodes:
//   - R/MEXT 0110011 (funct7 0000000 / 0100000 when alt / 0000001 for MEXT)
//   - OPIMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011
//   - JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111
// - Immediate legality (any violation = illegal):
//   - I/S/JALR: -2048..2047.
//   - B: -4096..4094, bit0 = 0.
//   - J: +/-1 MiB, bit0 = 0.
//   - U: imm[11:0] = 0.
//   - OPIMM shifts (funct3 001/101): imm[31:5] = 0, and alt=1 only with funct3 101.
// - Class/funct3 rules:
//   - Illegal: LOAD funct3 011/110/111; STORE funct3 >010; BRANCH funct3 010/011.
//   - MEXT ignores alt.
// - Illegal request: still consumes an address and writes NOP_WORD.
//   - err sets; err_addr captures the first occurrence only.
// - req_last with an illegal request still ends the load.
// - Reset mid-operation: immediate return to IDLE. An in-flight imem_we drops asynchronously; IMEM contents are undefined.
// STRUCTURE
// - Shared package/defines: class codes, 7-bit opcode constants, funct7 constants, NOP_WORD.
// - The same opcode constants are used by the control unit.
// - Sub-module rv_field_encoder: purely combinational (class, fields, imm -> word, illegal).
// - Top level holds FSM, output register, address counter and flags.
// TESTING
// - start, base 0x010, add x3,x1,x2 -> imem_addr 0x010, wdata 0x002081B3, word_count 1.
// - sub x5,x6,x7 then mul x10,x11,x12 back-to-back, imem_ready=1 -> 0x407302B3, 0x02C58533 on consecutive cycles.
// - addi x1,x0,-1 -> 0xFFF00093; beq x1,x2,-4 -> 0xFE208EE3; jal x1,+8 (last) -> 0x008000EF, then done pulse.
// - imem_ready low for 3 cycles during a write -> wdata/addr stable, req_ready 0, no request lost.
// - addi imm=4096, then slli imm=33 -> NOP_WORD written twice, err=1, err_addr = first address, count still advances.
// - AW=2, 5 requests -> 4 words written, full=1, 5th never accepted, done pulses; reset_n low mid-load -> all outputs 0 same cycle.

Source files
------------

// File: rtl/instr_encode_loader_pkg.sv
// Shared encoding constants for the IMEM program loader and the control unit.
// Class codes, RV32IM opcodes/funct7 values, loader FSM states and a range helper.
package instr_encode_loader_pkg;

    localparam logic [3:0] CLS_R      = 4'd0;
    localparam logic [3:0] CLS_OPIMM  = 4'd1;
    localparam logic [3:0] CLS_LOAD   = 4'd2;
    localparam logic [3:0] CLS_STORE  = 4'd3;
    localparam logic [3:0] CLS_BRANCH = 4'd4;
    localparam logic [3:0] CLS_JAL    = 4'd5;
    localparam logic [3:0] CLS_JALR   = 4'd6;
    localparam logic [3:0] CLS_LUI    = 4'd7;
    localparam logic [3:0] CLS_AUIPC  = 4'd8;
    localparam logic [3:0] CLS_MEXT   = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } ld_state_e;

    // True when v is representable as a two's-complement value of 'bits' bits.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] hi;
        hi = 32'($signed(v) >>> (bits - 1));
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/instr_encode_loader_rv_field_encoder.sv
// Combinational RV32IM encoder: instruction class plus fields in, 32-bit word and
// an illegal flag out (bad class, funct3 or immediate).
module rv_field_encoder
    import instr_encode_loader_pkg::*;
(
    input  logic [3:0]  i_class,
    input  logic [2:0]  i_funct3,
    input  logic        i_alt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    logic        w_shift;
    logic [6:0]  w_f7;

    assign w_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
    assign w_f7    = i_alt ? F7_ALT : F7_BASE;

    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        case (i_class)
            CLS_R:    o_word = {w_f7, i_rs2, i_rs1, i_funct3, i_rd, OPC_OP};
            CLS_MEXT: o_word = {F7_MEXT, i_rs2, i_rs1, i_funct3, i_rd, OPC_OP};
            CLS_OPIMM: begin
                if (w_shift) begin
                    o_illegal = (i_imm[31:5] != '0) || (i_alt && (i_funct3 != 3'b101));
                    o_word    = {w_f7, i_imm[4:0], i_rs1, i_funct3, i_rd, OPC_OPIMM};
                end else begin
                    o_illegal = !fits_signed(i_imm, 12);
                    o_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_OPIMM};
                end
            end
            CLS_LOAD: begin
                o_illegal = !fits_signed(i_imm, 12) || (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11);
                o_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_LOAD};
            end
            CLS_STORE: begin
                o_illegal = !fits_signed(i_imm, 12) || (i_funct3 > 3'b010);
                o_word    = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OPC_STORE};
            end
            CLS_BRANCH: begin
                o_illegal = !fits_signed(i_imm, 13) || i_imm[0] || (i_funct3[2:1] == 2'b01);
                o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], OPC_BRANCH};
            end
            CLS_JAL: begin
                o_illegal = !fits_signed(i_imm, 21) || i_imm[0];
                o_word    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
            end
            CLS_JALR: begin
                o_illegal = !fits_signed(i_imm, 12);
                o_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_JALR};
            end
            CLS_LUI: begin
                o_illegal = (i_imm[11:0] != '0);
                o_word    = {i_imm[31:12], i_rd, OPC_LUI};
            end
            CLS_AUIPC: begin
                o_illegal = (i_imm[11:0] != '0);
                o_word    = {i_imm[31:12], i_rd, OPC_AUIPC};
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Boot/bench program loader: encodes field-level requests and streams the words
// into IMEM from base_addr upward, flagging illegal requests and capacity overflow.
//   state    | meaning
//   ST_IDLE  | waiting for start; flags and count hold their last values
//   ST_LOAD  | accepting requests, one output word in flight at most
//   ST_DRAIN | last request taken (or IMEM full); waiting for the final write
module instr_encode_loader
    import instr_encode_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] NOP_WORD   = NOP_WORD_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_last,
    input  logic [3:0]            i_req_class,
    input  logic [2:0]            i_req_funct3,
    input  logic                  i_req_alt,
    input  logic [4:0]            i_req_rd,
    input  logic [4:0]            i_req_rs1,
    input  logic [4:0]            i_req_rs2,
    input  logic [31:0]           i_req_imm,
    output logic                  o_imem_we,
    input  logic                  i_imem_ready,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [31:0]           o_imem_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH:0]   o_word_count,
    output logic                  o_err,
    output logic [ADDR_WIDTH-1:0] o_err_addr,
    output logic                  o_full
);

    ld_state_e             r_state, w_next_state;
    logic                  r_we, r_err, r_full, r_done;
    logic [ADDR_WIDTH-1:0] r_addr, r_ptr, r_err_addr;
    logic [31:0]           r_wdata;
    logic [ADDR_WIDTH:0]   r_count;

    logic [31:0] w_word;
    logic        w_illegal, w_accept, w_wr_done, w_at_top, w_full_set, w_start;

    rv_field_encoder u_enc (
        .i_class   (i_req_class),
        .i_funct3  (i_req_funct3),
        .i_alt     (i_req_alt),
        .i_rd      (i_req_rd),
        .i_rs1     (i_req_rs1),
        .i_rs2     (i_req_rs2),
        .i_imm     (i_req_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign w_at_top   = (r_addr == {ADDR_WIDTH{1'b1}});
    assign w_wr_done  = r_we && i_imem_ready;
    assign w_full_set = w_wr_done && w_at_top;
    assign w_start    = (r_state == ST_IDLE) && i_start;
    // A word parked at the top address also blocks: accepting behind it would wrap.
    assign o_req_ready = (r_state == ST_LOAD) && !r_full && (!r_we || (i_imem_ready && !w_at_top));
    assign w_accept    = i_req_valid && o_req_ready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next_state = ST_LOAD;
            ST_LOAD:  if ((w_accept && i_req_last) || w_full_set) w_next_state = ST_DRAIN;
            ST_DRAIN: if (!r_we) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_next_state;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ptr      <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
            r_full     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DRAIN) && !r_we;
            if (w_start) begin
                r_ptr   <= i_base_addr;
                r_count <= '0;
                r_err   <= 1'b0;
                r_full  <= 1'b0;
            end
            if (w_accept) begin
                r_we    <= 1'b1;
                r_addr  <= r_ptr;
                r_wdata <= w_illegal ? NOP_WORD : w_word;
                r_ptr   <= r_ptr + 1'b1;
                if (w_illegal && !r_err) begin
                    r_err      <= 1'b1;
                    r_err_addr <= r_ptr;
                end
            end else if (w_wr_done) begin
                r_we <= 1'b0;
            end
            if (w_wr_done) begin
                r_count <= r_count + 1'b1;
                if (w_at_top) r_full <= 1'b1;
            end
        end
    end

    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = r_done;
    assign o_word_count = r_count;
    assign o_err        = r_err;
    assign o_err_addr   = r_err_addr;
    assign o_full       = r_full;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: directed program vectors plus randomized
// requests checked against an arithmetic reference encoder.
module tb_instr_encode_loader;

    localparam int AW = 10;

    logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          req_valid = 1'b0, req_last = 1'b0, req_alt = 1'b0, imem_ready = 1'b1;
    logic [3:0]    req_class = '0;
    logic [2:0]    req_funct3 = '0;
    logic [4:0]    req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [31:0]   req_imm = '0;

    logic          req_ready, imem_we, busy, done, err, full;
    logic [AW-1:0] imem_addr, err_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;

    instr_encode_loader #(.ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_base_addr(base_addr),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_last(req_last),
        .i_req_class(req_class), .i_req_funct3(req_funct3), .i_req_alt(req_alt),
        .i_req_rd(req_rd), .i_req_rs1(req_rs1), .i_req_rs2(req_rs2), .i_req_imm(req_imm),
        .o_imem_we(imem_we), .i_imem_ready(imem_ready), .o_imem_addr(imem_addr),
        .o_imem_wdata(imem_wdata), .o_busy(busy), .o_done(done), .o_word_count(word_count),
        .o_err(err), .o_err_addr(err_addr), .o_full(full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    int            n_checks = 0, n_fail = 0;
    logic [AW-1:0] m_addr = '0, m_err_addr = '0;
    int            m_count = 0;
    logic          m_err = 1'b0;
    logic          rand_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: legality from signed ranges, words from the ISA field layouts.
    function automatic logic [32:0] ref_enc(input logic [3:0] cls, input logic [2:0] f3,
                                            input logic alt, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [31:0] imm);
        int          s;
        logic        bad;
        logic [31:0] w;
        s   = $signed(imm);
        bad = 1'b0;
        w   = '0;
        case (cls)
            4'd0: w = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
            4'd9: w = {7'b0000001, rs2, rs1, f3, rd, 7'b0110011};
            4'd1: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    bad = (imm > 32'd31) || (alt && f3 == 3'd1);
                    w   = {1'b0, alt, 5'b0, imm[4:0], rs1, f3, rd, 7'b0010011};
                end else begin
                    bad = (s < -2048) || (s > 2047);
                    w   = {imm[11:0], rs1, f3, rd, 7'b0010011};
                end
            end
            4'd2: begin
                bad = (s < -2048) || (s > 2047) || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
                w   = {imm[11:0], rs1, f3, rd, 7'b0000011};
            end
            4'd3: begin
                bad = (s < -2048) || (s > 2047) || (f3 > 3'd2);
                w   = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            end
            4'd4: begin
                bad = (s < -4096) || (s > 4094) || imm[0] || f3 == 3'd2 || f3 == 3'd3;
                w   = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            end
            4'd5: begin
                bad = (s < -1048576) || (s > 1048574) || imm[0];
                w   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            end
            4'd6: begin
                bad = (s < -2048) || (s > 2047);
                w   = {imm[11:0], rs1, f3, rd, 7'b1100111};
            end
            4'd7: begin bad = (imm % 4096) != 0; w = {imm[31:12], rd, 7'b0110111}; end
            4'd8: begin bad = (imm % 4096) != 0; w = {imm[31:12], rd, 7'b0010111}; end
            default: bad = 1'b1;
        endcase
        if (bad) w = 32'h0000_0013;
        return {bad, w};
    endfunction

    task automatic do_start(input logic [AW-1:0] b);
        start     = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start   = 1'b0;
        m_addr  = b;
        m_count = 0;
        m_err   = 1'b0;
    endtask

    task automatic send(input logic [3:0] cls, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last,
                        input logic [31:0] exp_word, input logic exp_ill);
        logic accepted;
        req_class = cls; req_funct3 = f3; req_alt = alt;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_last = last; req_valid = 1'b1;
        accepted = 1'b0;
        for (int c = 0; c < 200 && !accepted; c++) begin
            @(negedge clk);
            if (req_ready) begin
                sb_q.push_back('{addr: m_addr, data: exp_word});
                if (exp_ill && !m_err) begin
                    m_err      = 1'b1;
                    m_err_addr = m_addr;
                end
                m_addr   = m_addr + 1'b1;
                m_count++;
                accepted = 1'b1;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        req_last  = 1'b0;
        chk("accept_timeout", accepted, 1);
    endtask

    task automatic send_rand(input logic last);
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, r;
        logic [32:0] e;
        cls = 4'($urandom_range(0, 11));
        f3  = 3'($urandom);
        alt = ($urandom % 4) == 0;
        rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        r   = $urandom;
        case ($urandom % 6)
            0: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
            1: imm = r;
            2: imm = r & 32'hFFFF_F000;
            3: imm = $urandom_range(0, 40);
            4: imm = 32'(int'($urandom_range(0, 8191)) - 4096) & ~32'd1;
            default: imm = 32'(int'($urandom_range(0, 2097151)) - 1048576) & ~32'd1;
        endcase
        e = ref_enc(cls, f3, alt, rd, rs1, rs2, imm);
        send(cls, f3, alt, rd, rs1, rs2, imm, last, e[31:0], e[32]);
    endtask

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("done_seen", got, 1);
        chk("busy_after_done", busy, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("scoreboard_empty", sb_q.size(), 0);
    endtask

    task automatic end_checks(input logic exp_full);
        chk("word_count", word_count, m_count);
        chk("err", err, m_err);
        if (m_err) chk("err_addr", err_addr, m_err_addr);
        chk("full", full, exp_full);
    endtask

    always @(negedge clk) begin
        if (reset_n && imem_we && imem_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0h data %0h with no expected word", imem_addr, imem_wdata);
            end else begin
                mon_e = sb_q.pop_front();
                chk("imem_addr", imem_addr, mon_e.addr);
                chk("imem_wdata", imem_wdata, mon_e.data);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            imem_ready = ($urandom % 4) != 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d checks %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc, got;
        repeat (2) @(negedge clk);
        chk("rst_we", imem_we, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", word_count, 0);
        chk("rst_err_full", {err, full}, 0);
        chk("rst_addr_data", {imem_addr, imem_wdata}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // single add
        do_start(10'h010);
        send(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, 1'b0);
        wait_done();
        end_checks(1'b0);

        // back-to-back program; start pulsed mid-load must be ignored
        do_start(10'h020);
        send(4'd0, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0, 32'h407302B3, 1'b0);
        start = 1'b1; base_addr = 10'h3AA;
        send(4'd9, 3'd0, 1'b0, 5'd10, 5'd11, 5'd12, 32'd0, 1'b0, 32'h02C58533, 1'b0);
        start = 1'b0;
        send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF00093, 1'b0);
        send(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0, 32'hFE208EE3, 1'b0);
        send(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 32'h008000EF, 1'b0);
        wait_done();
        end_checks(1'b0);

        // IMEM stall: word held stable, next request refused until ready
        do_start(10'h040);
        imem_ready = 1'b0;
        send(4'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd5, 1'b0, 32'h00500113, 1'b0);
        req_class = 4'd0; req_funct3 = 3'd0; req_alt = 1'b0;
        req_rd = 5'd3; req_rs1 = 5'd1; req_rs2 = 5'd2; req_last = 1'b1; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_we", imem_we, 1);
            chk("stall_addr", imem_addr, 10'h040);
            chk("stall_wdata", imem_wdata, 32'h00500113);
            chk("stall_req_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        imem_ready = 1'b1;
        send(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, 1'b0);
        wait_done();
        end_checks(1'b0);

        // illegal immediates: NOP written, first address captured
        do_start(10'h080);
        send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0, 32'h00000013, 1'b1);
        send(4'd1, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd33, 1'b1, 32'h00000013, 1'b1);
        wait_done();
        end_checks(1'b0);
        chk("illegal_err_addr", err_addr, 10'h080);

        // randomized program with random IMEM backpressure
        do_start(10'h100);
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) send_rand(i == 149);
        rand_ready = 1'b0;
        @(posedge clk); #2;
        imem_ready = 1'b1;
        wait_done();
        end_checks(1'b0);

        // capacity: four words fit below the top address, the fifth is refused
        do_start(10'h3FC);
        for (int i = 0; i < 4; i++) send_rand(1'b0);
        req_class = 4'd0; req_funct3 = 3'd0; req_alt = 1'b0; req_imm = '0;
        req_rd = 5'd3; req_rs1 = 5'd1; req_rs2 = 5'd2; req_last = 1'b0; req_valid = 1'b1;
        acc = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready) acc = 1'b1;
            if (done) got = 1'b1;
        end
        chk("fifth_refused", acc, 0);
        chk("done_after_full", got, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("full_scoreboard_empty", sb_q.size(), 0);
        end_checks(1'b1);

        // asynchronous reset with a write in flight
        do_start(10'h000);
        imem_ready = 1'b0;
        send(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h002081B3, 1'b0);
        @(negedge clk);
        chk("pre_reset_we", imem_we, 1);
        reset_n = 1'b0;
        #1;
        sb_q.delete();
        chk("arst_we", imem_we, 0);
        chk("arst_busy", busy, 0);
        chk("arst_req_ready", req_ready, 0);
        chk("arst_addr_data", {imem_addr, imem_wdata}, 0);
        chk("arst_flags", {done, err, full, word_count}, 0);
        @(posedge clk); #1;
        reset_n    = 1'b1;
        imem_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
